// File: rtl/uart_tx_engine.sv
// UART transmit engine: frame FSM, LSB-first serializer, parity generator and registered line driver.
// Optional macro UART_TX_STOP2_EN adds the STOP2 input for a selectable second stop bit.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`ifdef UART_TX_STOP2_EN
  input  logic                  STOP2,
`endif
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  ACCEPT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [CNT_W-1:0]        idx_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    last_stop;
  logic                    accept;

`ifdef UART_TX_STOP2_EN
  logic                    stop2_q;
  logic                    stop_cnt_q;

  // With two stop bits the frame ends only in the second stop cycle.
  assign last_stop = (state_q == S_STOP) && (!stop2_q || stop_cnt_q);
`else
  assign last_stop = (state_q == S_STOP);
`endif

  // A new frame may start from idle or seamlessly out of the final stop bit.
  assign accept = DATA_VALID && ((state_q == S_IDLE) || last_stop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the shift register is reset too, so an abandoned frame leaves no
      // stale payload behind; it is a handful of flops, not a memory array.
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
`endif
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      ACCEPT     <= 1'b0;
    end else begin
      ACCEPT <= 1'b0;
      if (accept) begin
        // Everything that shapes the frame is captured here and held to its end.
        state_q   <= S_START;
        shreg_q   <= P_DATA;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
`ifdef UART_TX_STOP2_EN
        stop2_q   <= STOP2;
`endif
        TX_OUT    <= 1'b0;
        Busy      <= 1'b1;
        ACCEPT    <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
          end

          S_START: begin
            state_q <= S_DATA;
            idx_q   <= '0;
            TX_OUT  <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            Busy    <= 1'b1;
          end

          S_DATA: begin
            Busy <= 1'b1;
            if (idx_q == LAST_IDX) begin
              if (par_en_q) begin
                state_q <= S_PARITY;
                TX_OUT  <= par_bit_q;
              end else begin
                state_q <= S_STOP;
                TX_OUT  <= 1'b1;
`ifdef UART_TX_STOP2_EN
                stop_cnt_q <= 1'b0;
`endif
              end
            end else begin
              idx_q   <= idx_q + CNT_W'(1);
              TX_OUT  <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end

          S_PARITY: begin
            state_q <= S_STOP;
            TX_OUT  <= 1'b1;
            Busy    <= 1'b1;
`ifdef UART_TX_STOP2_EN
            stop_cnt_q <= 1'b0;
`endif
          end

          S_STOP: begin
            TX_OUT <= 1'b1;
            if (last_stop) begin
              state_q <= S_IDLE;
              Busy    <= 1'b0;
            end else begin
              Busy <= 1'b1;
`ifdef UART_TX_STOP2_EN
              stop_cnt_q <= 1'b1;
`endif
            end
          end

          default: begin
            // Unused encodings fall back to a quiet idle line.
            state_q <= S_IDLE;
            TX_OUT  <= 1'b1;
            Busy    <= 1'b0;
            ACCEPT  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
